metro_ticket_vendor: RTL and testbench
======================================

# metro_ticket_vendor

Parametrised ticket vending controller for the metro ticket machine, the next generation of the fixed 4-destination `Top`. It latches a request (destination, ticket count), computes the fare, and collects coins through a valid/ready handshake. On full payment it issues tickets one per cycle and returns change. On cancel or inactivity timeout it returns a full refund. It sits between the front-panel/coin-acceptor logic and the ticket printer.

## Interface
Parameters:
- `NUM_DEST`, 8: number of destinations (≥2).
- `MAX_TICKETS`, 4: maximum tickets per transaction (≥1).
- `MONEY_W`, 12: width of money values.
- `FARE_BASE`, 10: fare for destination 0.
- `FARE_STEP`, 5: fare increment per destination index.
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before auto-refund.
- Derived: `DEST_W = $clog2(NUM_DEST)`, `CNT_W = $clog2(MAX_TICKETS+1)`.
- Constraint: `(FARE_BASE+(NUM_DEST-1)*FARE_STEP)*MAX_TICKETS < 2**MONEY_W`. Enforce with an elaboration-time assertion.

Ports:
- `clk` in 1: the block's single clock; all logic on the rising edge.
- `arstn` in 1: synchronous, active-low reset. The block has one clock; reset is synchronous and active-low.
- `transaction` in 1: request strobe; sampled only in IDLE.
- `cancel` in 1: user abort.
- `destination` in DEST_W: destination index.
- `ticket_count` in CNT_W: tickets requested.
- `coin_valid` in 1: coin present.
- `coin_amount` in MONEY_W: coin value.
- `coin_ready` out 1: coin accepted this cycle when high together with `coin_valid`. This output is combinational.
- `ticket_out` out 1: one-cycle pulse per ticket issued.
- `count` out CNT_W: tickets issued so far in the current transaction.
- `refund` out MONEY_W: refunded amount; held until the next accepted transaction.
- `change` out MONEY_W: change amount; held until the next accepted transaction.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high with `done` if the transaction was rejected, cancelled or timed out.
- `busy` out 1: high in any state other than IDLE.

## Operation
States and transitions:
- **IDLE**: go to CALC when `transaction=1`.
- **CALC**: latch request; compute `total = (FARE_BASE + dest*FARE_STEP) * ticket_count`.
  - Go to REJECT if `ticket_count==0`, `ticket_count>MAX_TICKETS` or `destination>=NUM_DEST`.
  - Otherwise go to COLLECT.
- **COLLECT**: accumulate coins into `paid`.
  - Go to REFUND on `cancel` or when the timer reaches TIMEOUT_CYCLES.
  - Go to DISPENSE when `paid >= total`.
- **DISPENSE**: pulse `ticket_out` and increment `count` each cycle. After the `ticket_count`-th pulse, go to FINISH.
- **FINISH**: `change <= paid - total`; `done=1`; go to IDLE.
- **REFUND**: `refund <= paid`; `done=1`; `err=1`; go to IDLE.
- **REJECT**: `done=1`; `err=1`; `refund=0`; go to IDLE.

Coin handshake:
- `coin_ready = (state==COLLECT) && !cancel && (paid + coin_amount` does not overflow MONEY_W`)`.
- A coin transfers on `coin_valid && coin_ready`.
- A rejected overflowing coin is not counted. It stays with the acceptor.

Timeout timer:
- Clears on entry to COLLECT and on every accepted coin.
- Otherwise increments by 1 each cycle in COLLECT.

Transaction capture:
- `change`, `refund`, `count`, `paid` and the timer clear on the cycle the transaction is accepted (IDLE→CALC).
- `transaction` is ignored while `busy`.

## Timing
- Reset (`arstn=0` at an edge):
  - State goes to IDLE.
  - All outputs go to 0: `ticket_out`, `count`, `refund`, `change`, `done`, `err`, `busy`.
  - Any transaction in progress is abandoned with no refund output.
- Transaction at edge k: CALC at k+1, COLLECT at k+2, so `coin_ready` can first be high in cycle k+2.
- Coin accepted at edge j: `paid` updates at j. If `paid >= total`, DISPENSE is entered at j+1.
- DISPENSE: `ticket_out` is high for exactly `ticket_count` consecutive cycles. FINISH and `done` follow in the next cycle.
- Simultaneous `cancel` and `coin_valid`: `cancel` wins and the coin is not accepted.
- Simultaneous `cancel` and payment completion on the same edge: `cancel` is not sampled and the transaction completes normally.
- `cancel` is ignored in DISPENSE and FINISH.
- Timeout: REFUND is entered TIMEOUT_CYCLES+1 cycles after the last accepted coin (or after COLLECT entry if no coin was accepted).
- Exact payment gives `change = 0` with `err = 0`.

## Structure
- Package `metro_pkg` holds:
  - the state enum `vend_state_t`;
  - the `fare_of(dest)` function;
  - a localparam helper for the width check.
- Sub-module `fare_calc`: registered multiply `fare*ticket_count` producing `total`, used in CALC.
- The rest (FSM, accumulator, timer, dispense counter) lives in `metro_ticket_vendor`.

## Test plan
All scenarios use the default parameters.
- **Normal purchase**: dest=2, cnt=3 (fare 20, total 60); coin 100 → `coin_ready` high, 3 consecutive `ticket_out` pulses, then `count=3`, `change=40`, `done=1`, `err=0`.
- **Multi-coin exact payment**: dest=0, cnt=2 (total 20); coins 5, 10, 5 with a gap cycle between them → DISPENSE one cycle after the third coin, `change=0`.
- **Cancel**: dest=7, cnt=1 (total 45); coins 20, 10, then `cancel` asserted together with `coin_valid` (coin 5) → coin refused, `refund=30`, `err=1`, no `ticket_out`.
- **Timeout**: TIMEOUT_CYCLES=16; one coin 10, then idle → `done`/`err` exactly 17 cycles after the coin, `refund=10`.
- **Reject**: `ticket_count=0`, then separately `ticket_count=5` → `done`/`err` 2 cycles after `transaction`; `coin_ready` never high.
- **Reset mid-DISPENSE**: `arstn=0` during the second `ticket_out` pulse → all outputs 0 next cycle; a new transaction is accepted normally afterwards.

Source files
------------

// File: rtl/metro_pkg.sv
// rtl/metro_pkg.sv - shared types and fare helpers for the metro ticket vendor
package metro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_COLLECT,
    ST_DISPENSE,
    ST_FINISH,
    ST_REFUND,
    ST_REJECT
  } vend_state_t;

  // Widest money value the width check can evaluate in 64-bit arithmetic
  localparam int unsigned MONEY_W_LIMIT = 62;

  function automatic int unsigned fare_of(input int unsigned dest,
                                          input int unsigned base,
                                          input int unsigned step);
    return base + dest * step;
  endfunction

  // True when the most expensive possible transaction fits in money_w bits
  function automatic bit total_fits(input int unsigned num_dest,
                                    input int unsigned max_tickets,
                                    input int unsigned base,
                                    input int unsigned step,
                                    input int unsigned money_w);
    logic [63:0] worst;
    worst = (64'(base) + 64'(num_dest - 1) * 64'(step)) * 64'(max_tickets);
    return (money_w <= MONEY_W_LIMIT) && (worst < (64'd1 << money_w));
  endfunction

  function automatic bit dest_ok(input int unsigned dest, input int unsigned num_dest);
    return dest < num_dest;
  endfunction

  function automatic bit count_ok(input int unsigned cnt, input int unsigned max_tickets);
    return (cnt != 0) && (cnt <= max_tickets);
  endfunction

endpackage

// File: rtl/fare_calc.sv
// rtl/fare_calc.sv - registered fare times ticket-count multiply
module fare_calc
  import metro_pkg::*;
#(
  parameter int MONEY_W   = 12,
  parameter int FARE_BASE = 10,
  parameter int FARE_STEP = 5,
  parameter int DEST_W    = 3,
  parameter int CNT_W     = 3
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               i_en,
  input  logic [DEST_W-1:0]  i_dest,
  input  logic [CNT_W-1:0]   i_count,
  output logic [MONEY_W-1:0] o_total
);

  logic [MONEY_W-1:0] r_total;

  // Capture the transaction total while the request is being evaluated
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_total <= '0;
    end else if (i_en) begin
      r_total <= MONEY_W'(fare_of(32'(i_dest), FARE_BASE, FARE_STEP) * 32'(i_count));
    end
  end

  assign o_total = r_total;

endmodule

// File: rtl/metro_ticket_vendor.sv
// rtl/metro_ticket_vendor.sv - ticket vending FSM with coin collection, dispense, change and refund
module metro_ticket_vendor
  import metro_pkg::*;
#(
  parameter int NUM_DEST       = 8,
  parameter int MAX_TICKETS    = 4,
  parameter int MONEY_W        = 12,
  parameter int FARE_BASE      = 10,
  parameter int FARE_STEP      = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int DEST_W        = $clog2(NUM_DEST),
  localparam int CNT_W         = $clog2(MAX_TICKETS + 1)
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               transaction,
  input  logic               cancel,
  input  logic [DEST_W-1:0]  destination,
  input  logic [CNT_W-1:0]   ticket_count,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_amount,
  output logic               coin_ready,
  output logic               ticket_out,
  output logic [CNT_W-1:0]   count,
  output logic [MONEY_W-1:0] refund,
  output logic [MONEY_W-1:0] change,
  output logic               done,
  output logic               err,
  output logic               busy
);

  // Sized so the timer can hold TIMEOUT_CYCLES and never collapses to zero width
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 2);

  if (!total_fits(NUM_DEST, MAX_TICKETS, FARE_BASE, FARE_STEP, MONEY_W)) begin : g_width_check
    $error("metro_ticket_vendor: MONEY_W too narrow for the largest transaction total");
  end

  vend_state_t        r_state;
  logic [DEST_W-1:0]  r_dest;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_count;
  logic [MONEY_W-1:0] r_paid;
  logic [MONEY_W-1:0] r_refund;
  logic [MONEY_W-1:0] r_change;
  logic [TMR_W-1:0]   r_timer;
  logic               r_ticket_out;
  logic               r_done;
  logic               r_err;

  logic [MONEY_W-1:0] w_total;
  logic [MONEY_W:0]   w_sum;
  logic               w_coin_fits;
  logic               w_coin_accept;
  logic               w_req_bad;
  logic               w_paid_enough;
  logic               w_timed_out;

  fare_calc #(
    .MONEY_W  (MONEY_W),
    .FARE_BASE(FARE_BASE),
    .FARE_STEP(FARE_STEP),
    .DEST_W   (DEST_W),
    .CNT_W    (CNT_W)
  ) u_fare_calc (
    .clk    (clk),
    .arstn  (arstn),
    .i_en   (r_state == ST_CALC),
    .i_dest (r_dest),
    .i_count(r_cnt),
    .o_total(w_total)
  );

  // A coin is refused if adding it would wrap the paid accumulator
  assign w_sum         = {1'b0, r_paid} + {1'b0, coin_amount};
  assign w_coin_fits   = !w_sum[MONEY_W];
  assign coin_ready    = (r_state == ST_COLLECT) && !cancel && w_coin_fits;
  assign w_coin_accept = coin_valid && coin_ready;
  assign w_req_bad     = !count_ok(32'(r_cnt), MAX_TICKETS) || !dest_ok(32'(r_dest), NUM_DEST);
  assign w_paid_enough = (r_paid >= w_total);
  assign w_timed_out   = (r_timer == TMR_W'(TIMEOUT_CYCLES));

  // Main controller: request capture, coin collection, dispensing and completion
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state      <= ST_IDLE;
      r_dest       <= '0;
      r_cnt        <= '0;
      r_count      <= '0;
      r_paid       <= '0;
      r_refund     <= '0;
      r_change     <= '0;
      r_timer      <= '0;
      r_ticket_out <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ticket_out <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (transaction) begin
            r_dest   <= destination;
            r_cnt    <= ticket_count;
            r_count  <= '0;
            r_paid   <= '0;
            r_refund <= '0;
            r_change <= '0;
            r_timer  <= '0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_req_bad) begin
            r_refund <= '0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_REJECT;
          end else begin
            r_timer <= '0;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_coin_accept) begin
            r_paid  <= w_sum[MONEY_W-1:0];
            r_timer <= '0;
          end else if (!w_timed_out) begin
            r_timer <= r_timer + TMR_W'(1);
          end
          // Completed payment takes priority over a cancel seen on the same edge
          if (w_paid_enough) begin
            r_ticket_out <= 1'b1;
            r_count      <= CNT_W'(1);
            r_state      <= ST_DISPENSE;
          end else if (cancel || (w_timed_out && !w_coin_accept)) begin
            r_refund <= r_paid;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_REFUND;
          end
        end
        ST_DISPENSE: begin
          if (r_count < r_cnt) begin
            r_ticket_out <= 1'b1;
            r_count      <= r_count + CNT_W'(1);
          end else begin
            r_change <= r_paid - w_total;
            r_done   <= 1'b1;
            r_state  <= ST_FINISH;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        ST_REFUND: r_state <= ST_IDLE;
        ST_REJECT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign ticket_out = r_ticket_out;
  assign count      = r_count;
  assign refund     = r_refund;
  assign change     = r_change;
  assign done       = r_done;
  assign err        = r_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_metro_ticket_vendor.sv
// tb/tb_metro_ticket_vendor.sv - directed and randomized checks of the ticket vendor
module tb_metro_ticket_vendor;

  localparam int NUM_DEST    = 8;
  localparam int MAX_TICKETS = 4;
  localparam int MONEY_W     = 12;
  localparam int FARE_BASE   = 10;
  localparam int FARE_STEP   = 5;
  localparam int TIMEOUT     = 16;
  localparam int DEST_W      = 3;
  localparam int CNT_W       = 3;

  logic               clk = 1'b0;
  logic               arstn = 1'b0;
  logic               transaction = 1'b0;
  logic               cancel = 1'b0;
  logic [DEST_W-1:0]  destination = '0;
  logic [CNT_W-1:0]   ticket_count = '0;
  logic               coin_valid = 1'b0;
  logic [MONEY_W-1:0] coin_amount = '0;
  wire                coin_ready;
  wire                ticket_out;
  wire  [CNT_W-1:0]   count;
  wire  [MONEY_W-1:0] refund;
  wire  [MONEY_W-1:0] change;
  wire                done;
  wire                err;
  wire                busy;

  int total_n = 0;
  int bad_n   = 0;

  always #5 clk = ~clk;

  metro_ticket_vendor #(
    .NUM_DEST      (NUM_DEST),
    .MAX_TICKETS   (MAX_TICKETS),
    .MONEY_W       (MONEY_W),
    .FARE_BASE     (FARE_BASE),
    .FARE_STEP     (FARE_STEP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .arstn       (arstn),
    .transaction (transaction),
    .cancel      (cancel),
    .destination (destination),
    .ticket_count(ticket_count),
    .coin_valid  (coin_valid),
    .coin_amount (coin_amount),
    .coin_ready  (coin_ready),
    .ticket_out  (ticket_out),
    .count       (count),
    .refund      (refund),
    .change      (change),
    .done        (done),
    .err         (err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input int d, input int c);
    destination  = DEST_W'(d);
    ticket_count = CNT_W'(c);
    transaction  = 1'b1;
    tick();
    transaction  = 1'b0;
  endtask

  task automatic pay(input string tag, input int amt);
    coin_valid  = 1'b1;
    coin_amount = MONEY_W'(amt);
    #1;
    check(tag, 32'(coin_ready), 1);
    tick();
    coin_valid  = 1'b0;
  endtask

  // Steps until done, counting ticket pulses and cycles taken
  task automatic finish_txn(input string tag, output int pulses, output int waited);
    pulses = 0;
    waited = 0;
    while (!done && waited < 40) begin
      if (ticket_out) pulses++;
      tick();
      waited++;
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic to_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  function automatic int fare_total(input int d, input int c);
    return (FARE_BASE + d * FARE_STEP) * c;
  endfunction

  initial begin
    int d, c, mode, tot, paid, amt, pulses, waited, n, room, k, gap;

    // Reset state
    tick();
    tick();
    check("rst_ticket", 32'(ticket_out), 0);
    check("rst_count", 32'(count), 0);
    check("rst_refund", 32'(refund), 0);
    check("rst_change", 32'(change), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    arstn = 1'b1;
    tick();

    // Normal purchase: dest 2, 3 tickets, total 60, coin 100
    start(2, 3);
    check("norm_busy", 32'(busy), 1);
    tick();
    pay("norm_ready", 100);
    check("norm_no_early_ticket", 32'(ticket_out), 0);
    finish_txn("norm", pulses, waited);
    check("norm_pulses", 32'(pulses), 3);
    check("norm_latency", 32'(waited), 4);
    check("norm_count", 32'(count), 3);
    check("norm_change", 32'(change), 40);
    check("norm_err", 32'(err), 0);
    to_idle("norm");

    // Multi-coin exact payment with gaps; a stray transaction while busy is ignored
    start(0, 2);
    tick();
    pay("multi_c1", 5);
    transaction  = 1'b1;
    destination  = 3'd7;
    ticket_count = 3'd4;
    tick();
    transaction  = 1'b0;
    pay("multi_c2", 10);
    tick();
    pay("multi_c3", 5);
    check("multi_still_collect", 32'(ticket_out), 0);
    tick();
    check("multi_dispense_next", 32'(ticket_out), 1);
    finish_txn("multi", pulses, waited);
    check("multi_pulses", 32'(pulses), 2);
    check("multi_change", 32'(change), 0);
    check("multi_err", 32'(err), 0);
    to_idle("multi");

    // Cancel together with a coin: coin refused, refund what was paid
    start(7, 1);
    tick();
    pay("cancel_c1", 20);
    pay("cancel_c2", 10);
    cancel      = 1'b1;
    coin_valid  = 1'b1;
    coin_amount = 12'd5;
    #1;
    check("cancel_ready_low", 32'(coin_ready), 0);
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    check("cancel_done", 32'(done), 1);
    check("cancel_err", 32'(err), 1);
    check("cancel_refund", 32'(refund), 30);
    check("cancel_no_ticket", 32'(ticket_out), 0);
    to_idle("cancel");

    // Timeout: one coin then silence
    start(1, 1);
    tick();
    pay("tmo_coin", 10);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("tmo_latency", 32'(n), TIMEOUT + 1);
    check("tmo_err", 32'(err), 1);
    check("tmo_refund", 32'(refund), 10);
    to_idle("tmo");

    // Reject: zero tickets, then too many tickets
    for (int r = 0; r < 2; r++) begin
      start(3, (r == 0) ? 0 : 5);
      coin_valid  = 1'b1;
      coin_amount = 12'd10;
      #1;
      check("rej_ready_calc", 32'(coin_ready), 0);
      check("rej_done_early", 32'(done), 0);
      tick();
      #1;
      check("rej_ready_rej", 32'(coin_ready), 0);
      check("rej_done", 32'(done), 1);
      check("rej_err", 32'(err), 1);
      check("rej_refund", 32'(refund), 0);
      coin_valid = 1'b0;
      to_idle("rej");
    end

    // Overflowing coin is refused and not counted
    start(0, 1);
    tick();
    pay("ovf_c1", 4);
    coin_amount = 12'd4092;
    #1;
    check("ovf_ready_over", 32'(coin_ready), 0);
    coin_amount = 12'd4091;
    #1;
    check("ovf_ready_edge", 32'(coin_ready), 1);
    coin_valid  = 1'b1;
    coin_amount = 12'd4092;
    tick();
    coin_valid = 1'b0;
    pay("ovf_c2", 6);
    finish_txn("ovf", pulses, waited);
    check("ovf_pulses", 32'(pulses), 1);
    check("ovf_change", 32'(change), 0);
    to_idle("ovf");

    // Reset during the second ticket pulse
    start(0, 3);
    tick();
    pay("rstd_coin", 30);
    tick();
    tick();
    check("rstd_second_pulse", 32'(ticket_out), 1);
    check("rstd_count2", 32'(count), 2);
    arstn = 1'b0;
    tick();
    arstn = 1'b1;
    check("rstd_ticket", 32'(ticket_out), 0);
    check("rstd_count", 32'(count), 0);
    check("rstd_refund", 32'(refund), 0);
    check("rstd_change", 32'(change), 0);
    check("rstd_done", 32'(done), 0);
    check("rstd_err", 32'(err), 0);
    check("rstd_busy", 32'(busy), 0);
    start(4, 1);
    tick();
    pay("rstd_new_coin", 30);
    finish_txn("rstd_new", pulses, waited);
    check("rstd_new_pulses", 32'(pulses), 1);
    check("rstd_new_change", 32'(change), 0);
    to_idle("rstd_new");

    // Randomized transactions against the fare/outcome model
    for (int it = 0; it < 40; it++) begin
      d    = int'($urandom_range(0, NUM_DEST - 1));
      c    = int'($urandom_range(0, MAX_TICKETS + 1));
      mode = int'($urandom_range(0, 3));
      tot  = fare_total(d, c);
      paid = 0;
      start(d, c);
      tick();
      if (c == 0 || c > MAX_TICKETS) begin
        check("rnd_rej_done", 32'(done), 1);
        check("rnd_rej_err", 32'(err), 1);
        check("rnd_rej_refund", 32'(refund), 0);
      end else if (mode <= 1) begin
        while (paid < tot) begin
          amt = int'($urandom_range(1, 60));
          pay("rnd_pay_ready", amt);
          paid += amt;
          gap = int'($urandom_range(0, 2));
          if (paid < tot) repeat (gap) tick();
        end
        finish_txn("rnd_pay", pulses, waited);
        check("rnd_pay_pulses", 32'(pulses), 32'(c));
        check("rnd_pay_latency", 32'(waited), 32'(c + 1));
        check("rnd_pay_count", 32'(count), 32'(c));
        check("rnd_pay_change", 32'(change), 32'(paid - tot));
        check("rnd_pay_err", 32'(err), 0);
      end else if (mode == 2) begin
        k = int'($urandom_range(0, 2));
        for (int j = 0; j < k; j++) begin
          room = tot - paid - 1;
          if (room > 0) begin
            amt = int'($urandom_range(1, (room < 40) ? room : 40));
            pay("rnd_can_ready", amt);
            paid += amt;
          end
        end
        cancel      = 1'b1;
        coin_valid  = 1'b1;
        coin_amount = MONEY_W'($urandom_range(1, 20));
        #1;
        check("rnd_can_ready_low", 32'(coin_ready), 0);
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        check("rnd_can_done", 32'(done), 1);
        check("rnd_can_err", 32'(err), 1);
        check("rnd_can_refund", 32'(refund), 32'(paid));
        check("rnd_can_ticket", 32'(ticket_out), 0);
      end else begin
        amt = int'($urandom_range(1, tot - 1));
        pay("rnd_tmo_ready", amt);
        paid = amt;
        n = 0;
        while (!done && n < 40) begin
          tick();
          n++;
        end
        check("rnd_tmo_latency", 32'(n), TIMEOUT + 1);
        check("rnd_tmo_err", 32'(err), 1);
        check("rnd_tmo_refund", 32'(refund), 32'(paid));
      end
      to_idle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
